// File: rtl/jpeg_output_rgb_if.sv
// rtl/jpeg_output_rgb_if.sv - Y/Cb/Cr FIFO pop ports and RGB pixel output stream
interface jpeg_output_rgb_if;
   logic        y_valid_i;
   logic [31:0] y_data_i;
   logic        y_pop_o;
   logic        cb_valid_i;
   logic [31:0] cb_data_i;
   logic        cb_pop_o;
   logic        cr_valid_i;
   logic [31:0] cr_data_i;
   logic        cr_pop_o;
   logic        out_valid_o;
   logic [31:0] out_data_o;
   logic        out_last_o;
   logic        out_accept_i;

   // Converter side
   modport slave (
      input  y_valid_i, y_data_i, cb_valid_i, cb_data_i, cr_valid_i, cr_data_i, out_accept_i,
      output y_pop_o, cb_pop_o, cr_pop_o, out_valid_o, out_data_o, out_last_o
   );

   // FIFO / downstream side
   modport master (
      output y_valid_i, y_data_i, cb_valid_i, cb_data_i, cr_valid_i, cr_data_i, out_accept_i,
      input  y_pop_o, cb_pop_o, cr_pop_o, out_valid_o, out_data_o, out_last_o
   );
endinterface

// File: rtl/jpeg_output_rgb.sv
// rtl/jpeg_output_rgb.sv - three-stage YCbCr to RGB converter with 8x8 block pixel counter
module jpeg_output_rgb #(
   parameter logic [7:0] ALPHA = 8'h00
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              mono_i,
   input  logic              flush_i,
   output logic              idle_o,
   jpeg_output_rgb_if.slave  bus
);

   logic               advance;
   logic               fire;
   logic               s1_valid, s2_valid, s3_valid;
   logic [7:0]         s1_y, s2_y;
   logic signed [8:0]  s1_cbo, s1_cro;
   logic signed [8:0]  cbo_d, cro_d;
   logic signed [18:0] cbo_x, cro_x;
   logic signed [18:0] pr_d, pgb_d, pgr_d, pb_d;
   logic signed [18:0] s2_pr, s2_pgb, s2_pgr, s2_pb;
   logic signed [18:0] g_prod;
   logic [10:0]        r_sum, g_sum, b_sum;
   logic [23:0]        s3_rgb;
   logic [5:0]         pix_cnt;
   logic               unused_bits;

   function automatic logic [7:0] clamp8(input logic [10:0] s);
      if (s[10])
         return 8'h00;
      else if (s[9:8] != 2'b00)
         return 8'hFF;
      else
         return s[7:0];
   endfunction

   // Pops are gated by reset so nothing is consumed while the pipeline is held clear
   assign advance = !s3_valid || bus.out_accept_i;
   assign fire    = rst_i && advance && !flush_i && bus.y_valid_i &&
                    (mono_i || (bus.cb_valid_i && bus.cr_valid_i));

   assign bus.y_pop_o  = fire;
   assign bus.cb_pop_o = fire && !mono_i;
   assign bus.cr_pop_o = fire && !mono_i;

   // Greyscale is carried per pixel as zero chroma offsets
   assign cbo_d = mono_i ? 9'sd0 : $signed({1'b0, bus.cb_data_i[7:0]} - 9'd128);
   assign cro_d = mono_i ? 9'sd0 : $signed({1'b0, bus.cr_data_i[7:0]} - 9'd128);

   assign cbo_x = {{10{s1_cbo[8]}}, s1_cbo};
   assign cro_x = {{10{s1_cro[8]}}, s1_cro};
   assign pr_d  = cro_x * 19'sd359;
   assign pgb_d = cbo_x * 19'sd88;
   assign pgr_d = cro_x * 19'sd183;
   assign pb_d  = cbo_x * 19'sd454;

   // Bits [18:8] are the floor-divided-by-256 value as 11-bit two's complement
   assign g_prod = -s2_pgb - s2_pgr;
   assign r_sum  = {3'b000, s2_y} + s2_pr[18:8];
   assign g_sum  = {3'b000, s2_y} + g_prod[18:8];
   assign b_sum  = {3'b000, s2_y} + s2_pb[18:8];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s1_y     <= 8'h00;
         s1_cbo   <= 9'sd0;
         s1_cro   <= 9'sd0;
         s2_y     <= 8'h00;
         s2_pr    <= 19'sd0;
         s2_pgb   <= 19'sd0;
         s2_pgr   <= 19'sd0;
         s2_pb    <= 19'sd0;
         s3_rgb   <= 24'h000000;
         pix_cnt  <= 6'd0;
      end else begin
         if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
         end else if (advance) begin
            s1_valid <= fire;
            s2_valid <= s1_valid;
            s3_valid <= s2_valid;
         end
         if (advance) begin
            s1_y   <= bus.y_data_i[7:0];
            s1_cbo <= cbo_d;
            s1_cro <= cro_d;
            s2_y   <= s1_y;
            s2_pr  <= pr_d;
            s2_pgb <= pgb_d;
            s2_pgr <= pgr_d;
            s2_pb  <= pb_d;
            s3_rgb <= {clamp8(r_sum), clamp8(g_sum), clamp8(b_sum)};
         end
         if (flush_i)
            pix_cnt <= 6'd0;
         else if (s3_valid && bus.out_accept_i)
            pix_cnt <= pix_cnt + 6'd1;
      end
   end

   assign bus.out_valid_o = s3_valid;
   assign bus.out_data_o  = {ALPHA, s3_rgb};
   assign bus.out_last_o  = s3_valid && (pix_cnt == 6'd63);
   assign idle_o          = !(s1_valid || s2_valid || s3_valid);

   assign unused_bits = ^{bus.y_data_i[31:8], bus.cb_data_i[31:8], bus.cr_data_i[31:8]};

endmodule

// File: tb/tb_jpeg_output_rgb.sv
// tb/tb_jpeg_output_rgb.sv - directed-vector bench for jpeg_output_rgb
module tb_jpeg_output_rgb;

   logic clk_i;
   logic rst_i;
   logic mono_i;
   logic flush_i;
   logic idle_o;
   int   checks;
   int   failures;
   logic [31:0] exp_q[$];

   jpeg_output_rgb_if bus ();

   jpeg_output_rgb #(.ALPHA(8'h00)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .mono_i  (mono_i),
      .flush_i (flush_i),
      .idle_o  (idle_o),
      .bus     (bus.slave)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int clamp(input int v);
      if (v < 0) return 0;
      if (v > 255) return 255;
      return v;
   endfunction

   function automatic logic [31:0] model(input int y, input int cb, input int cr, input bit mono);
      int cbo, cro, r, g, b;
      cbo = mono ? 0 : cb - 128;
      cro = mono ? 0 : cr - 128;
      r = clamp(y + ((359 * cro) >>> 8));
      g = clamp(y + ((-88 * cbo - 183 * cro) >>> 8));
      b = clamp(y + ((454 * cbo) >>> 8));
      return {8'h00, 8'(r), 8'(g), 8'(b)};
   endfunction

   task automatic drive(input logic [7:0] y, input logic [7:0] cb, input logic [7:0] cr,
                        input bit mono, input bit yv, input bit cbv, input bit crv);
      bus.y_data_i   = {24'hABCDEF, y};
      bus.cb_data_i  = {24'h123456, cb};
      bus.cr_data_i  = {24'hFEDCBA, cr};
      bus.y_valid_i  = yv;
      bus.cb_valid_i = cbv;
      bus.cr_valid_i = crv;
      mono_i         = mono;
   endtask

   task automatic one_pixel(input string tag, input logic [7:0] y, input logic [7:0] cb,
                            input logic [7:0] cr, input bit mono, input bit cbv, input bit crv,
                            input logic [31:0] exp);
      int lat;
      @(posedge clk_i); #1;
      drive(y, cb, cr, mono, 1'b1, cbv, crv);
      @(negedge clk_i);
      check({tag, "_ypop"}, bus.y_pop_o, 1'b1);
      check({tag, "_cbpop"}, bus.cb_pop_o, !mono);
      check({tag, "_crpop"}, bus.cr_pop_o, !mono);
      @(posedge clk_i); #1;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      lat = 0;
      do begin
         @(negedge clk_i);
         lat++;
      end while (!bus.out_valid_o && lat < 8);
      check({tag, "_latency"}, lat, 3);
      check({tag, "_data"}, bus.out_data_o, exp);
      check({tag, "_last"}, bus.out_last_o, 1'b0);
   endtask

   task automatic producer();
      logic [7:0] yv, cbv, crv;
      bit mono;
      int w;
      for (int i = 0; i < 128; i++) begin
         yv   = 8'(i * 37 + 5);
         cbv  = 8'(i * 91 + 17);
         crv  = 8'(255 - i * 13);
         mono = (i % 7 == 3);
         @(posedge clk_i); #1;
         drive(yv, cbv, crv, mono, 1'b1, 1'b1, 1'b1);
         w = 0;
         do begin
            @(negedge clk_i);
            w++;
         end while (!bus.y_pop_o && w < 200);
         if (!bus.y_pop_o)
            check("stream_pop_timeout", 32'd0, 32'd1);
         else begin
            exp_q.push_back(model(yv, cbv, crv, mono));
            if (mono) check("stream_mono_cbpop", bus.cb_pop_o, 1'b0);
         end
      end
      @(posedge clk_i); #1;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic consumer();
      int got, cyc;
      bit stalled;
      logic [31:0] held, exp;
      got = 0;
      cyc = 0;
      stalled = 0;
      held = 32'h0;
      while (got < 128 && cyc < 4000) begin
         @(posedge clk_i); #1;
         bus.out_accept_i = 1'($urandom_range(0, 1));
         @(negedge clk_i);
         cyc++;
         if (bus.out_valid_o) begin
            if (stalled) check("stall_hold", bus.out_data_o, held);
            if (bus.out_accept_i) begin
               if (exp_q.size() == 0) begin
                  check("stream_extra", 32'd1, 32'd0);
               end else begin
                  exp = exp_q.pop_front();
                  check("stream_data", bus.out_data_o, exp);
               end
               check("stream_last", bus.out_last_o, (got % 64) == 63);
               got++;
               stalled = 0;
            end else begin
               stalled = 1;
               held = bus.out_data_o;
            end
         end else begin
            if (stalled) check("stall_valid_drop", 32'd0, 32'd1);
            stalled = 0;
         end
      end
      check("stream_count", got, 128);
      @(posedge clk_i); #1;
      bus.out_accept_i = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_i    = 1'b0;
      flush_i  = 1'b0;
      bus.out_accept_i = 1'b1;
      drive(8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (2) @(negedge clk_i);
      check("rst_valid", bus.out_valid_o, 1'b0);
      check("rst_data", bus.out_data_o, 32'h00000000);
      check("rst_last", bus.out_last_o, 1'b0);
      check("rst_idle", idle_o, 1'b1);
      check("rst_ypop", bus.y_pop_o, 1'b0);
      check("rst_cbpop", bus.cb_pop_o, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

      one_pixel("mid_grey", 8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 32'h00808080);
      one_pixel("all_zero", 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 32'h00008700);
      one_pixel("hi_red",   8'hFF, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, 32'h00FFA4FF);
      one_pixel("mono",     8'h5A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 32'h005A5A5A);
      one_pixel("mixed",    8'h10, 8'hF0, 8'h20, 1'b0, 1'b1, 1'b1, 32'h00002ED6);
      one_pixel("mono_cv",  8'h33, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 32'h00333333);

      // Colour mode with Cr missing must not pop anything
      @(posedge clk_i); #1;
      drive(8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
      @(negedge clk_i);
      check("nocr_ypop", bus.y_pop_o, 1'b0);
      check("nocr_cbpop", bus.cb_pop_o, 1'b0);
      check("nocr_crpop", bus.cr_pop_o, 1'b0);

      // Three pixels in flight, then flush
      @(posedge clk_i); #1;
      drive(8'h80, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
      repeat (3) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      @(negedge clk_i);
      check("flush_ypop", bus.y_pop_o, 1'b0);
      check("flush_inflight", bus.out_valid_o, 1'b1);
      @(posedge clk_i); #1;
      flush_i = 1'b0;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      @(negedge clk_i);
      check("flush_valid", bus.out_valid_o, 1'b0);
      check("flush_idle", idle_o, 1'b1);
      check("flush_last", bus.out_last_o, 1'b0);

      fork
         producer();
         consumer();
      join
      check("stream_queue_empty", exp_q.size(), 0);

      // Asynchronous reset with a pixel in flight
      @(posedge clk_i); #1;
      drive(8'h40, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b1);
      @(posedge clk_i); #2;
      rst_i = 1'b0;
      #1;
      check("arst_idle", idle_o, 1'b1);
      check("arst_valid", bus.out_valid_o, 1'b0);
      check("arst_ypop", bus.y_pop_o, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      one_pixel("post_rst", 8'hFF, 8'h80, 8'hFF, 1'b0, 1'b1, 1'b1, 32'h00FFA4FF);
      @(negedge clk_i);
      check("end_idle", idle_o, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
